// File: rtl/update_knn18_mul_arbiter.sv
// Round-robin arbiter sharing one 2-stage 17x15 multiplier between NUM_REQ requesters.
// Optional stats counters enabled by UPDATE_KNN18_MUL_ARB_STATS_EN.
module update_knn18_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 17,
  parameter int B_W     = 15,
  parameter int P_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [P_W-1:0]         res_p,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
`ifdef UPDATE_KNN18_MUL_ARB_STATS_EN
  input  logic [P_W-1:0]         mul_dout,
  output logic [31:0]            stat_issue_cnt,
  output logic [31:0]            stat_stall_cnt
`else
  input  logic [P_W-1:0]         mul_dout
`endif
);

  logic            v0;
  logic            v1;
  logic [ID_W-1:0] id0;
  logic [ID_W-1:0] id1;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] rr_nxt;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any;
  logic            adv;
  logic            hs;
  int              sel;

  assign adv    = ~v1 | res_ready;
  assign mul_ce = adv;
  assign hs     = adv & gnt_any & ~reset;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    sel     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = int'(rr_ptr) + k;
      if (sel >= NUM_REQ) sel = sel - NUM_REQ;
      if (!gnt_any && req_valid[sel]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(sel);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_idx] = 1'b1;
  end

  assign mul_din0 = hs ? req_a[int'(gnt_idx)*A_W +: A_W] : '0;
  assign mul_din1 = hs ? req_b[int'(gnt_idx)*B_W +: B_W] : '0;

  assign rr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0
                : gnt_idx + 1'b1;

  // shadow of the multiplier pipeline, stepped by the same ce
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0     <= 1'b0;
      v1     <= 1'b0;
      id0    <= '0;
      id1    <= '0;
      rr_ptr <= '0;
    end else if (adv) begin
      v0  <= hs;
      id0 <= gnt_idx;
      v1  <= v0;
      id1 <= id0;
      if (hs) rr_ptr <= rr_nxt;
    end
  end

  assign res_valid = v1;
  assign res_id    = id1;
  assign res_p     = mul_dout;

`ifdef UPDATE_KNN18_MUL_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (hs && stat_issue_cnt != '1)
        stat_issue_cnt <= stat_issue_cnt + 1'b1;
      if (v1 && !res_ready && stat_stall_cnt != '1)
        stat_stall_cnt <= stat_stall_cnt + 1'b1;
    end
  end
`endif

endmodule
